// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: FSM state encoding,
// architectural register indices and the source/destination match helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } state_e;

    localparam logic [4:0] ZERO_REGISTER           = 5'd0;
    localparam logic [4:0] RETURN_ADDRESS_REGISTER = 5'd1;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic reg_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] rd);
        return uses && (rd != ZERO_REGISTER) && (src == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller: drives PC / IF/ID enables and ID/EX bubbles from
// load-use hazards, EX redirects and imem wait states; keeps event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int FETCH_TIMEOUT   = 255,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1_ind,
    input  logic [4:0]       ID_rs2_ind,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             EX_memread,
    input  logic [4:0]       EX_rd_ind,
    input  logic             EX_branch_taken,
    input  logic             imem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_Write,
    output logic             IF_FLUSH,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             fetch_timeout
);

    // Timeout counter must be able to reach FETCH_TIMEOUT+1 before saturating.
    localparam int              TO_W        = $clog2(FETCH_TIMEOUT + 2);
    localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(FETCH_TIMEOUT);
    localparam bit              MULTI_STALL = (LOAD_USE_STALLS > 1);
    localparam logic [3:0]      LS_INIT     = MULTI_STALL ? 4'(LOAD_USE_STALLS - 2) : 4'd0;

    state_e          state, state_nxt;
    logic [3:0]      ls_cnt, ls_nxt;
    logic            luh;
    logic [TO_W-1:0] to_cnt, to_inc;

    assign luh = EX_memread &&
                 (reg_match(ID_uses_rs1, ID_rs1_ind, EX_rd_ind) ||
                  reg_match(ID_uses_rs2, ID_rs2_ind, EX_rd_ind));

    always_comb begin
        pc_write    = 1'b0;
        if_id_Write = 1'b0;
        IF_FLUSH    = 1'b0;
        id_ex_flush = 1'b0;
        state_nxt   = state;
        ls_nxt      = ls_cnt;
        if (!rst) begin
            state_nxt = RUN;
            ls_nxt    = 4'd0;
        end else if (EX_branch_taken) begin
            pc_write    = 1'b1;
            if_id_Write = 1'b1;
            IF_FLUSH    = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
        end else if ((state == RUN && luh) || state == LOAD_STALL) begin
            // ID keeps its instruction; only EX receives a bubble.
            id_ex_flush = 1'b1;
            if (state == RUN) begin
                if (MULTI_STALL) begin
                    state_nxt = LOAD_STALL;
                    ls_nxt    = LS_INIT;
                end
            end else if (ls_cnt == 4'd0) begin
                state_nxt = RUN;
            end else begin
                ls_nxt = ls_cnt - 4'd1;
            end
        end else if (!imem_ready) begin
            if_id_Write = 1'b1;
            IF_FLUSH    = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_Write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            ls_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            ls_cnt <= ls_nxt;
        end
    end

    assign to_inc = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt        <= '0;
            fetch_timeout <= 1'b0;
        end else if (cnt_clr) begin
            to_cnt        <= '0;
            fetch_timeout <= 1'b0;
        end else if (!imem_ready) begin
            to_cnt <= to_inc;
            if (to_inc > TO_LIMIT) begin
                fetch_timeout <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (!pc_write),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (rst && EX_branch_taken),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle priority vectors from a
// table plus hand-written multi-cycle sequences for stalls, reset and counters.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ID_rs1_ind, ID_rs2_ind, EX_rd_ind;
    logic             ID_uses_rs1, ID_uses_rs2, EX_memread, EX_branch_taken;
    logic             imem_ready, cnt_clr;
    logic             pc_write, if_id_Write, IF_FLUSH, id_ex_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             fetch_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       rdy;
        logic [3:0] exp_ctl;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .LOAD_USE_STALLS (2),
        .FETCH_TIMEOUT   (2),
        .CNT_W           (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs1_ind      (ID_rs1_ind),
        .ID_rs2_ind      (ID_rs2_ind),
        .ID_uses_rs1     (ID_uses_rs1),
        .ID_uses_rs2     (ID_uses_rs2),
        .EX_memread      (EX_memread),
        .EX_rd_ind       (EX_rd_ind),
        .EX_branch_taken (EX_branch_taken),
        .imem_ready      (imem_ready),
        .cnt_clr         (cnt_clr),
        .pc_write        (pc_write),
        .if_id_Write     (if_id_Write),
        .IF_FLUSH        (IF_FLUSH),
        .id_ex_flush     (id_ex_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .fetch_timeout   (fetch_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [3:0] exp);
        chk(name, {28'd0, pc_write, if_id_Write, IF_FLUSH, id_ex_flush}, {28'd0, exp});
    endtask

    task automatic idle();
        ID_rs1_ind      = 5'd0;
        ID_rs2_ind      = 5'd0;
        ID_uses_rs1     = 1'b0;
        ID_uses_rs2     = 1'b0;
        EX_memread      = 1'b0;
        EX_rd_ind       = 5'd0;
        EX_branch_taken = 1'b0;
        imem_ready      = 1'b1;
        cnt_clr         = 1'b0;
    endtask

    task automatic set_luh();
        EX_memread  = 1'b1;
        EX_rd_ind   = 5'd5;
        ID_rs2_ind  = 5'd5;
        ID_uses_rs2 = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rs1    rs2    u1    u2    mr    rd     br    rdy   {pcw,ifw,iff,idf}
        vecs[0] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 4'b1100};
        vecs[1] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 4'b0001};
        vecs[2] = '{5'd3,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 4'b0001};
        vecs[3] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 4'b1100};
        vecs[4] = '{5'd4,  5'd9,  1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 4'b1100};
        vecs[5] = '{5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b1, 4'b1100};
        vecs[6] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'b0110};
        vecs[7] = '{5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 4'b0001};
        vecs[8] = '{5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 4'b1111};
        vecs[9] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 4'b1111};

        idle();
        rst = 1'b0;
        #12;
        chk_ctl("reset_ctl", 4'b0000);
        chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        chk("reset_timeout", {31'd0, fetch_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            ID_rs1_ind      = vecs[i].rs1;
            ID_rs2_ind      = vecs[i].rs2;
            ID_uses_rs1     = vecs[i].u1;
            ID_uses_rs2     = vecs[i].u2;
            EX_memread      = vecs[i].mr;
            EX_rd_ind       = vecs[i].rd;
            EX_branch_taken = vecs[i].br;
            imem_ready      = vecs[i].rdy;
            @(negedge clk);
            chk_ctl($sformatf("vec%0d", i), vecs[i].exp_ctl);
            idle();
            next_cycle();
            next_cycle();
        end

        // Two-cycle load-use stall; the bubble clears memread in EX after the first cycle.
        clear_counters();
        set_luh();
        @(negedge clk);
        chk_ctl("luh_cycle1", 4'b0001);
        next_cycle();
        idle();
        @(negedge clk);
        chk_ctl("luh_cycle2", 4'b0001);
        next_cycle();
        @(negedge clk);
        chk_ctl("luh_cycle3", 4'b1100);
        chk("luh_stall_cnt", {28'd0, stall_cnt}, 32'd2);
        next_cycle();

        // Redirect beats a pending load-use hazard and an imem wait state.
        clear_counters();
        set_luh();
        EX_branch_taken = 1'b1;
        imem_ready      = 1'b0;
        @(negedge clk);
        chk_ctl("br_over_luh", 4'b1111);
        next_cycle();
        idle();
        @(negedge clk);
        chk_ctl("br_next_run", 4'b1100);
        chk("br_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        chk("br_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        next_cycle();

        // Asynchronous reset while in LOAD_STALL.
        set_luh();
        next_cycle();
        idle();
        @(negedge clk);
        chk_ctl("pre_rst_stall", 4'b0001);
        #1 rst = 1'b0;
        #1;
        chk_ctl("rst_mid_stall", 4'b0000);
        chk("rst_mid_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        next_cycle();
        chk_ctl("rst_held", 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_ctl("post_rst_run", 4'b1100);
        next_cycle();

        // Three imem wait cycles against FETCH_TIMEOUT=2.
        clear_counters();
        imem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk_ctl($sformatf("wait_cycle%0d", k), 4'b0110);
            if (k == 3) chk("timeout_not_yet", {31'd0, fetch_timeout}, 32'd0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("timeout_set", {31'd0, fetch_timeout}, 32'd1);
        chk("wait_stall_cnt", {28'd0, stall_cnt}, 32'd3);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);
        cnt_clr = 1'b1;
        #1;
        chk("timeout_clr_same_cycle", {31'd0, fetch_timeout}, 32'd1);
        next_cycle();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("timeout_cleared", {31'd0, fetch_timeout}, 32'd0);
        chk("stall_cnt_cleared", {28'd0, stall_cnt}, 32'd0);
        next_cycle();

        // Saturation of the 4-bit stall counter.
        imem_ready = 1'b0;
        repeat (20) next_cycle();
        idle();
        @(negedge clk);
        chk("stall_cnt_sat", {28'd0, stall_cnt}, 32'h0000_000F);
        next_cycle();
        @(negedge clk);
        chk("stall_cnt_sat_hold", {28'd0, stall_cnt}, 32'h0000_000F);
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("stall_cnt_sat_clr", {28'd0, stall_cnt}, 32'd0);
        chk("flush_cnt_sat_clr", {28'd0, flush_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
